// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator CPU memory arbiter: FSM encodings,
// IO word address, port ids and address classification.
package acc_pkg;

  localparam int unsigned BUS_AW = 16;
  localparam logic [BUS_AW-1:0] IO_ADDR_DEF = 16'hfffe;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_RAM = 2'd0,
    KIND_IO  = 2'd1,
    KIND_BAD = 2'd2
  } kind_e;

  // The IO word wins over the RAM window; anything else above the RAM is invalid.
  function automatic kind_e decode_kind(input logic [BUS_AW-1:0] addr,
                                        input logic [BUS_AW-1:0] io_addr,
                                        input int unsigned       aw);
    kind_e k;
    if (addr == io_addr)              k = KIND_IO;
    else if ((addr >> aw) == 16'd0)   k = KIND_RAM;
    else                              k = KIND_BAD;
    return k;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: a lone request always wins; ties go to port 0 when fixed,
// otherwise to the port that did not win last time.
module rr_arb2
  import acc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  input  logic       fixed,
  output logic       win_id
);

  always_comb begin
    win_id = PORT0;
    case (req)
      2'b10:   win_id = PORT1;
      2'b11:   win_id = fixed ? PORT0 : ~last_win;
      default: win_id = PORT0;
    endcase
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Shares the single-port synchronous RAM between the CPU datapath (port 0) and
// the loader/DMA (port 1), decoding the memory-mapped IO word on the way.
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 10,
  parameter int unsigned       DATA_WIDTH = 16,
  parameter logic [BUS_AW-1:0] IO_ADDR    = IO_ADDR_DEF,
  parameter bit                FIXED_PRIO = 1'b0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [BUS_AW-1:0]     addr0,
  input  logic [BUS_AW-1:0]     addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  input  logic [DATA_WIDTH-1:0] IOIn,
  output logic [DATA_WIDTH-1:0] IOOut
);

  state_e                state_q, state_d;
  logic                  last_win_q, last_win_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  kind_e                 kind_q, kind_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] io_out_q, io_out_d;
  logic [DATA_WIDTH-1:0] io_in_q, io_in_d;

  logic                  win_id;
  logic                  sel_we;
  logic [BUS_AW-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  kind_e                 sel_kind;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .last_win (last_win_q),
    .fixed    (1'(FIXED_PRIO)),
    .win_id   (win_id)
  );

  assign sel_we    = (win_id == PORT1) ? we1    : we0;
  assign sel_addr  = (win_id == PORT1) ? addr1  : addr0;
  assign sel_wdata = (win_id == PORT1) ? wdata1 : wdata0;
  assign sel_kind  = decode_kind(sel_addr, IO_ADDR, ADDR_WIDTH);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      last_win_q <= PORT1;
      id_q       <= PORT0;
      we_q       <= 1'b0;
      kind_q     <= KIND_RAM;
      wdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      io_out_q   <= '0;
      io_in_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      id_q       <= id_d;
      we_q       <= we_d;
      kind_q     <= kind_d;
      wdata_q    <= wdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      io_out_q   <= io_out_d;
      io_in_q    <= io_in_d;
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    id_d       = id_q;
    we_d       = we_q;
    kind_d     = kind_q;
    wdata_d    = wdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    err_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    io_out_d   = io_out_q;
    io_in_d    = io_in_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d       = win_id;
          last_win_d = win_id;
          we_d       = sel_we;
          kind_d     = sel_kind;
          wdata_d    = sel_wdata;
          mem_addr_d = ADDR_WIDTH'(sel_addr);
          mem_data_d = sel_wdata;
          mem_we_d   = sel_we && (sel_kind == KIND_RAM);
          gnt0_d     = (win_id == PORT0);
          gnt1_d     = (win_id == PORT1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rvalid0_d = (id_q == PORT0);
        rvalid1_d = (id_q == PORT1);
        err_d     = (kind_q == KIND_BAD);
        io_in_d   = IOIn;
        if (we_q && (kind_q == KIND_IO)) io_out_d = wdata_q;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM read data arrives in the response cycle itself, so rdata is steered combinationally.
  always_comb begin
    rdata = '0;
    if ((rvalid0_q || rvalid1_q) && !we_q) begin
      case (kind_q)
        KIND_RAM: rdata = mem_q;
        KIND_IO:  rdata = io_in_q;
        default:  rdata = '0;
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign err      = err_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q & ~Reset;
  assign IOOut    = io_out_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench for acc_mem_arbiter: round-robin and fixed-priority instances,
// with a behavioural 1-cycle-latency RAM on the round-robin instance.
module tb_acc_mem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [15:0] rdata, mem_data, mem_q, IOIn, IOOut;
  logic [9:0]  mem_addr;

  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_err, fp_mem_we;
  logic [15:0] fp_rdata, fp_mem_data, fp_IOOut;
  logic [9:0]  fp_mem_addr;

  logic [15:0] ram [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  acc_mem_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .IOIn(IOIn), .IOOut(IOOut)
  );

  acc_mem_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rdata(fp_rdata), .err(fp_err),
    .mem_addr(fp_mem_addr), .mem_data(fp_mem_data), .mem_we(fp_mem_we), .mem_q(16'h0000),
    .IOIn(IOIn), .IOOut(fp_IOOut)
  );

  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Grant/rvalid must stay one-hot on both instances at all times.
  always @(negedge CLK) begin
    if (Reset === 1'b0) begin
      check_eq("gnt_onehot",    32'(gnt0 & gnt1),       32'd0);
      check_eq("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
      check_eq("fp_gnt_onehot", 32'(fp_gnt0 & fp_gnt1), 32'd0);
    end
  end

  // One complete access from IDLE: grant at T+1, response at T+2, idle again at T+3.
  task automatic access(input string tag, input bit port, input logic we,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err);
    logic in_ram;
    in_ram = (addr < 16'h0400);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    tick;
    check_eq({tag, "_gnt"},    {30'd0, gnt1, gnt0}, port ? 32'd2 : 32'd1);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'(we && in_ram));
    if (in_ram) check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr[9:0]));
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    check_eq({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, port ? 32'd2 : 32'd1);
    check_eq({tag, "_rdata"},  32'(rdata), 32'(exp_rd));
    check_eq({tag, "_err"},    32'(err), 32'(exp_err));
    tick;
    check_eq({tag, "_idle"},   {28'd0, gnt1, gnt0, rvalid1, rvalid0}, 32'd0);
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 16'hA000 | 16'(i);
    ram[5] <= 16'h1234;
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    IOIn = 16'h0000;
    do_reset;

    // Reset state
    check_eq("rst_pulses", {27'd0, gnt0, gnt1, rvalid0, rvalid1, err}, 32'd0);
    check_eq("rst_mem",    {15'd0, mem_we, 6'd0, mem_addr}, 32'd0);
    check_eq("rst_data",   {mem_data, IOOut}, 32'd0);
    check_eq("rst_rdata",  32'(rdata), 32'd0);

    // 1: plain read
    access("rd5", 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0);

    // 2: continuous tie for four rounds
    do_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0006;
    for (int r = 0; r < 4; r++) begin
      tick;
      check_eq($sformatf("rr_gnt_r%0d", r), {30'd0, gnt1, gnt0}, (r % 2 == 0) ? 32'd1 : 32'd2);
      check_eq($sformatf("fp_gnt_r%0d", r), {30'd0, fp_gnt1, fp_gnt0}, 32'd1);
      tick;
      check_eq($sformatf("rr_rdata_r%0d", r), 32'(rdata), (r % 2 == 0) ? 32'h1234 : 32'hA006);
      if (r == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick;
    end
    tick;
    check_eq("tie_done", {30'd0, gnt1, gnt0}, 32'd0);

    // 3: IO word write then read
    access("io_wr", 1'b0, 1'b1, 16'hfffe, 16'hBEEF, 16'h0000, 1'b0);
    check_eq("io_out", 32'(IOOut), 32'h0000BEEF);
    IOIn = 16'h00A5;
    access("io_rd", 1'b1, 1'b0, 16'hfffe, 16'h0000, 16'h00A5, 1'b0);

    // 4: out-of-range write and read
    access("bad_wr", 1'b0, 1'b1, 16'h0800, 16'h1111, 16'h0000, 1'b1);
    check_eq("bad_wr_ram0", 32'(ram[0]), 32'h0000A000);
    access("bad_rd", 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1);

    // 5: reset during ISSUE of a RAM write
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h7777;
    tick;
    check_eq("rst_issue_gnt", 32'(gnt0), 32'd1);
    Reset = 1'b1;
    req0 = 1'b0;
    #1;
    check_eq("rst_issue_mem_we", 32'(mem_we), 32'd0);
    tick;
    Reset = 1'b0;
    check_eq("rst_issue_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check_eq("rst_issue_ioout",  32'(IOOut), 32'd0);
    check_eq("rst_issue_ram3",   32'(ram[3]), 32'h0000A003);
    access("rd3_after_rst", 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA003, 1'b0);

    // 6: loader write, CPU read back
    access("ld_wr2",  1'b1, 1'b1, 16'h0002, 16'h5555, 16'h0000, 1'b0);
    access("cpu_rd2", 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h5555, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
